// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

  localparam int ARB_NPORTS = 2;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Default-width view of a latched access; the arbiter builds its own
  // parameter-sized copy of the same layout.
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [ARB_NPORTS-1:0] req,
  input  logic                  last_grant,
  output logic [ARB_NPORTS-1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between the CPU (port 0) and the loader/DMA
// (port 1), sequencing each access as IDLE -> ISSUE -> WAIT -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  arb_state_t              state;
  logic [3:0]              cnt;
  logic                    last_grant;
  logic [ARB_NPORTS-1:0]   owner;
  logic [ARB_NPORTS-1:0]   pick;
  logic [ARB_NPORTS-1:0]   ready_vec;
  req_t                    req_q;
  logic [DATA_W-1:0]       rdata_q;

  rr_arb2 u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick) begin
            req_q      <= pick[1] ? req_t'{m1_we, m1_addr, m1_wdata}
                                  : req_t'{m0_we, m0_addr, m0_wdata};
            owner      <= pick;
            last_grant <= pick[1];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(MEM_LAT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            // Writes leave the last read result untouched.
            if (!req_q.we) begin
              rdata_q <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          owner <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready pulses only in RESP; gnt is visible only while the access is in flight.
  generate
    for (genvar gi = 0; gi < ARB_NPORTS; gi++) begin : g_ready
      assign ready_vec[gi] = (state == RESP) && owner[gi];
    end
  endgenerate

  assign m0_ready  = ready_vec[0];
  assign m1_ready  = ready_vec[1];
  assign gnt       = ((state == ISSUE) || (state == WAIT)) ? owner : 2'b00;
  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=1 instance for most scenarios, MEM_LAT=4 for latency.
module tb_mem_arbiter;

  logic        clk;
  logic        rstn;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] rdata;
  logic [1:0]  gnt;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        d4_m0_req, d4_m0_we, d4_m1_req, d4_m1_we;
  logic [31:0] d4_m0_addr, d4_m0_wdata, d4_m1_addr, d4_m1_wdata;
  logic        d4_m0_ready, d4_m1_ready;
  logic [31:0] d4_rdata;
  logic [1:0]  d4_gnt;
  logic        d4_mem_en, d4_mem_we;
  logic [31:0] d4_mem_addr, d4_mem_wdata, d4_mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .rdata(rdata), .gnt(gnt), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut4 (
    .clk(clk), .rstn(rstn),
    .m0_req(d4_m0_req), .m0_we(d4_m0_we), .m0_addr(d4_m0_addr), .m0_wdata(d4_m0_wdata), .m0_ready(d4_m0_ready),
    .m1_req(d4_m1_req), .m1_we(d4_m1_we), .m1_addr(d4_m1_addr), .m1_wdata(d4_m1_wdata), .m1_ready(d4_m1_ready),
    .rdata(d4_rdata), .gnt(d4_gnt), .mem_en(d4_mem_en), .mem_we(d4_mem_we),
    .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_rdata(d4_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs set afterwards are sampled at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;
    d4_m0_req = 0; d4_m0_we = 0; d4_m0_addr = '0; d4_m0_wdata = '0;
    d4_m1_req = 0; d4_m1_we = 0; d4_m1_addr = '0; d4_m1_wdata = '0;
    d4_mem_rdata = '0;
    tick();
    tick();
    checks++;
    if ({mem_en, mem_we, gnt, m0_ready, m1_ready} !== 6'b0 || rdata !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: en=%b we=%b gnt=%b r0=%b r1=%b rdata=%h addr=%h wdata=%h required all zero",
               mem_en, mem_we, gnt, m0_ready, m1_ready, rdata, mem_addr, mem_wdata);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (mem_en !== 1'b0 || gnt !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset: en=%b gnt=%b required 0 00", mem_en, gnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'h40; mem_rdata = 32'h0BAD0000;
    tick();  // T+1 ISSUE
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || gnt !== 2'b01 || m0_ready !== 1'b0) begin
      failures++;
      $display("FAIL read_issue: en=%b we=%b addr=%h gnt=%b r0=%b required 1 0 00000040 01 0",
               mem_en, mem_we, mem_addr, gnt, m0_ready);
    end
    mem_rdata = 32'h11111111;
    tick();  // T+2 WAIT
    checks++;
    if (mem_en !== 1'b0 || gnt !== 2'b01 || m0_ready !== 1'b0) begin
      failures++;
      $display("FAIL read_wait: en=%b gnt=%b r0=%b required 0 01 0", mem_en, gnt, m0_ready);
    end
    mem_rdata = 32'hDEADBEEF;
    tick();  // T+3 RESP
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || rdata !== 32'hDEADBEEF || gnt !== 2'b00 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL read_resp: r0=%b r1=%b rdata=%h gnt=%b en=%b required 1 0 deadbeef 00 0",
               m0_ready, m1_ready, rdata, gnt, mem_en);
    end
    m0_req = 0; mem_rdata = 32'h22222222;
    tick();
    checks++;
    if (m0_ready !== 1'b0 || mem_en !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_after: r0=%b en=%b rdata=%h required 0 0 deadbeef", m0_ready, mem_en, rdata);
    end
    $display("test_single_read done");
  endtask

  task automatic test_loader_write();
    m1_req = 1; m1_we = 1; m1_addr = 32'h10; m1_wdata = 32'h12345678; mem_rdata = 32'h33333333;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h12345678 || gnt !== 2'b10) begin
      failures++;
      $display("FAIL write_issue: en=%b we=%b addr=%h wdata=%h gnt=%b required 1 1 00000010 12345678 10",
               mem_en, mem_we, mem_addr, mem_wdata, gnt);
    end
    tick();
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || m1_ready !== 1'b0) begin
      failures++;
      $display("FAIL write_wait: en=%b we=%b r1=%b required 0 0 0", mem_en, mem_we, m1_ready);
    end
    tick();
    checks++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_resp: r1=%b r0=%b rdata=%h required 1 0 deadbeef", m1_ready, m0_ready, rdata);
    end
    m1_req = 0; m1_we = 0;
    tick();
    $display("test_loader_write done");
  endtask

  // Both ports hold req for four transactions; each takes four cycles.
  task automatic test_back_to_back();
    logic [1:0]  exp_gnt;
    logic        exp_r0, exp_r1;
    logic [31:0] exp_rdata;
    int          txn;
    m0_req = 1; m0_we = 0; m0_addr = 32'hA0;
    m1_req = 1; m1_we = 0; m1_addr = 32'hB0;
    mem_rdata = 32'hC0000000;
    exp_rdata = 32'hDEADBEEF;
    for (int k = 1; k <= 16; k++) begin
      tick();
      txn     = (k - 1) / 4;
      exp_gnt = 2'b00; exp_r0 = 0; exp_r1 = 0;
      if ((k % 4) == 1 || (k % 4) == 2) exp_gnt = txn[0] ? 2'b10 : 2'b01;
      if ((k % 4) == 3) begin
        exp_r0    = ~txn[0];
        exp_r1    = txn[0];
        exp_rdata = 32'hC0000000 + 32'(k - 1);
      end
      checks++;
      if (gnt !== exp_gnt || m0_ready !== exp_r0 || m1_ready !== exp_r1 || rdata !== exp_rdata ||
          (m0_ready && m1_ready)) begin
        failures++;
        $display("FAIL rr_cycle%0d: gnt=%b r0=%b r1=%b rdata=%h required %b %b %b %h",
                 k, gnt, m0_ready, m1_ready, rdata, exp_gnt, exp_r0, exp_r1, exp_rdata);
      end
      if ((k % 4) == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== (txn[0] ? 32'hB0 : 32'hA0)) begin
          failures++;
          $display("FAIL rr_addr_txn%0d: en=%b addr=%h required 1 %h", txn, mem_en, mem_addr,
                   txn[0] ? 32'hB0 : 32'hA0);
        end
      end
      if (k == 15) begin
        m0_req = 0; m1_req = 0;
      end
      mem_rdata = 32'hC0000000 + 32'(k);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_latency4();
    logic exp_r0, exp_en;
    d4_m0_req = 1; d4_m0_we = 0; d4_m0_addr = 32'h80; d4_mem_rdata = 32'hB0000000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_r0 = (k == 6);
      exp_en = (k == 1);
      checks++;
      if (d4_m0_ready !== exp_r0 || d4_mem_en !== exp_en) begin
        failures++;
        $display("FAIL lat4_cycle%0d: r0=%b en=%b required %b %b", k, d4_m0_ready, d4_mem_en, exp_r0, exp_en);
      end
      if (k == 6) begin
        checks++;
        if (d4_rdata !== 32'hB0000005) begin
          failures++;
          $display("FAIL lat4_rdata: rdata=%h required b0000005", d4_rdata);
        end
        d4_m0_req = 0;
      end
      d4_mem_rdata = 32'hB0000000 + 32'(k);
    end
    $display("test_latency4 done");
  endtask

  task automatic test_reset_mid();
    m1_req = 1; m1_we = 0; m1_addr = 32'h50; mem_rdata = 32'h55555555;
    tick();  // ISSUE
    tick();  // WAIT
    checks++;
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL midrst_pre: gnt=%b required 10", gnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || gnt !== 2'b00 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_async: en=%b gnt=%b r0=%b r1=%b required 0 00 0 0", mem_en, gnt, m0_ready, m1_ready);
    end
    tick();
    checks++;
    if (m1_ready !== 1'b0 || rdata !== 32'h0) begin
      failures++;
      $display("FAIL midrst_noresp: r1=%b rdata=%h required 0 00000000", m1_ready, rdata);
    end
    rstn = 1'b1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h60;
    tick();
    checks++;
    if (gnt !== 2'b01 || mem_en !== 1'b1 || mem_addr !== 32'h60) begin
      failures++;
      $display("FAIL midrst_tie: gnt=%b en=%b addr=%h required 01 1 00000060", gnt, mem_en, mem_addr);
    end
    tick();
    tick();
    m0_req = 0; m1_req = 0;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_drop_req();
    m0_req = 1; m0_we = 0; m0_addr = 32'h30; mem_rdata = 32'h66666666;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h30) begin
      failures++;
      $display("FAIL drop_issue: en=%b addr=%h required 1 00000030", mem_en, mem_addr);
    end
    tick();  // WAIT
    m0_req = 0; m0_addr = 32'h99;
    mem_rdata = 32'h77777777;
    tick();
    checks++;
    if (m0_ready !== 1'b1 || mem_addr !== 32'h30 || rdata !== 32'h77777777) begin
      failures++;
      $display("FAIL drop_resp: r0=%b addr=%h rdata=%h required 1 00000030 77777777", m0_ready, mem_addr, rdata);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (mem_en !== 1'b0 || gnt !== 2'b00 || m0_ready !== 1'b0) begin
        failures++;
        $display("FAIL drop_idle%0d: en=%b gnt=%b r0=%b required 0 00 0", k, mem_en, gnt, m0_ready);
      end
    end
    $display("test_drop_req done");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_loader_write();
    test_back_to_back();
    test_latency4();
    test_reset_mid();
    test_drop_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
